// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - 12-bit serial framer: start, 9 data bits LSB first, parity, stop
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       par_bit
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int             CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;
  logic          take;
  logic          bit_end;
  logic          par_next;

  assign din_ready = ~busy;
  assign take      = din_valid & din_ready;
  assign bit_end   = (bit_cnt == CNT_LAST);
  assign par_next  = (^din) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= 4'd0;
      shreg   <= 9'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= 4'd0;
          tx      <= 1'b1;
          if (take) begin
            shreg   <= din;
            par_bit <= par_next;
            state   <= START;
            busy    <= 1'b1;
            tx      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 4'd0;
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= {1'b0, shreg[8:1]};
            // shreg[1] becomes the LSB after this shift, so it is the next bit on the line
            if (bit_idx == 4'd8) begin
              bit_idx <= 4'd0;
              state   <= PARITY;
              tx      <= par_bit;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= STOP;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            tx      <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          bit_idx <= 4'd0;
          busy    <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - scoreboard bench for parity_frame_tx (three parameter sets)
module tb_parity_frame_tx;

  typedef struct {
    int         k;
    logic [8:0] w;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] din_a [3];
  logic [2:0] valid_v;
  logic [2:0] rdy_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] par_w;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   idle_cnt;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din_a[0]), .din_valid(valid_v[0]),
    .din_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .par_bit(par_w[0]));

  parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din_a[1]), .din_valid(valid_v[1]),
    .din_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .par_bit(par_w[1]));

  parity_frame_tx #(.CLKS_PER_BIT(2), .PARITY_ODD(0)) u_min (
    .clk(clk), .rst_n(rst_n), .din(din_a[2]), .din_valid(valid_v[2]),
    .din_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .par_bit(par_w[2]));

  function automatic int cpb_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  function automatic bit odd_of(input int k);
    return (k == 1);
  endfunction

  function automatic logic [11:0] exp_frame(input logic [8:0] w, input bit odd);
    logic [11:0] f;
    int ones;
    ones = 0;
    f = 12'd0;
    for (int i = 0; i < 9; i++) begin
      if (w[i]) ones++;
      f[i+1] = w[i];
    end
    f[0]  = 1'b0;
    f[10] = ((ones % 2) == 1) ^ odd;
    f[11] = 1'b1;
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [8:0] w, input bit hold);
    @(negedge clk);
    din_a[k]   = w;
    valid_v[k] = 1'b1;
    sb.push_back('{k, w});
    @(posedge clk);
    #1;
    if (!hold) begin
      valid_v[k] = 1'b0;
      din_a[k]   = ~w;
    end
  endtask

  task automatic wait_frame(input int k, output int idle);
    exp_t        e;
    logic [11:0] got;
    logic [11:0] want;
    logic        s;
    int          cpb;
    int          busy_n;
    int          rdy_n;
    bit          glitch;
    cpb    = cpb_of(k);
    idle   = 0;
    got    = 12'd0;
    busy_n = 0;
    rdy_n  = 0;
    glitch = 1'b0;
    @(negedge clk);
    while (tx_w[k] === 1'b1 && idle < 200) begin
      idle++;
      @(negedge clk);
    end
    if (idle >= 200) begin
      check("frame_start_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    e    = sb.pop_front();
    want = exp_frame(e.w, odd_of(k));
    check("frame_inst", k, e.k);
    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        s = tx_w[k];
        if (c == 0) got[b] = s;
        else if (s !== got[b]) glitch = 1'b1;
        if (busy_w[k] === 1'b1) busy_n++;
        if (rdy_w[k] === 1'b1) rdy_n++;
      end
    end
    check("frame_bits", {20'd0, got}, {20'd0, want});
    check("bit_stable", {31'd0, glitch}, 0);
    check("busy_cycles", busy_n, 12 * cpb);
    check("ready_low_in_frame", rdy_n, 0);
    check("par_bit", {31'd0, par_w[k]}, {31'd0, want[10]});
  endtask

  task automatic post_idle(input int k);
    @(negedge clk);
    check("idle_tx", {31'd0, tx_w[k]}, 1);
    check("idle_busy", {31'd0, busy_w[k]}, 0);
    check("idle_ready", {31'd0, rdy_w[k]}, 1);
  endtask

  task automatic quiet(input int k, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0) bad++;
    end
    check("quiet_line", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t dropped;
    rst_n   = 1'b0;
    valid_v = 3'b000;
    for (int k = 0; k < 3; k++) din_a[k] = 9'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_tx", {31'd0, tx_w[k]}, 1);
      check("rst_busy", {31'd0, busy_w[k]}, 0);
      check("rst_ready", {31'd0, rdy_w[k]}, 1);
      check("rst_par", {31'd0, par_w[k]}, 0);
    end
    rst_n = 1'b1;

    // even parity, latency and din isolation after transfer
    send(0, 9'h0A5, 1'b0);
    wait_frame(0, idle_cnt);
    check("even_latency", idle_cnt, 0);
    post_idle(0);

    // odd parity on all-ones word, then the same word with even parity
    send(1, 9'h1FF, 1'b0);
    wait_frame(1, idle_cnt);
    check("odd_latency", idle_cnt, 0);
    post_idle(1);
    send(0, 9'h1FF, 1'b0);
    wait_frame(0, idle_cnt);
    post_idle(0);

    // minimum divider
    send(2, 9'h000, 1'b0);
    wait_frame(2, idle_cnt);
    check("min_latency", idle_cnt, 0);
    post_idle(2);

    // back-to-back with din_valid held high
    send(0, 9'h001, 1'b1);
    din_a[0] = 9'h100;
    sb.push_back('{0, 9'h100});
    wait_frame(0, idle_cnt);
    check("b2b_first_latency", idle_cnt, 0);
    fork
      wait_frame(0, idle_cnt);
      begin
        @(negedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
      end
    join
    check("b2b_gap", idle_cnt + cpb_of(0), 5);
    quiet(0, 10);

    // word offered mid-frame is dropped
    send(0, 9'h0C3, 1'b0);
    fork
      wait_frame(0, idle_cnt);
      begin
        repeat (10) @(negedge clk);
        din_a[0]   = 9'h155;
        valid_v[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("offer_ready_low", {31'd0, rdy_w[0]}, 0);
        valid_v[0] = 1'b0;
      end
    join
    quiet(0, 12);
    check("sb_empty", sb.size(), 0);

    // reset during data bit 3, then request held across release
    send(0, 9'h133, 1'b0);
    repeat (18) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx_w[0]}, 1);
    check("abort_busy", {31'd0, busy_w[0]}, 0);
    check("abort_ready", {31'd0, rdy_w[0]}, 1);
    dropped    = sb.pop_front();
    din_a[0]   = 9'h0F1;
    valid_v[0] = 1'b1;
    sb.push_back('{0, 9'h0F1});
    @(posedge clk);
    #1;
    check("rst_no_take_busy", {31'd0, busy_w[0]}, 0);
    check("rst_par_clear", {31'd0, par_w[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    wait_frame(0, idle_cnt);
    check("release_latency", idle_cnt, 0);
    post_idle(0);
    check("sb_drained", sb.size() + (dropped.k - dropped.k), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
